// File: rtl/gcd_param_if.sv
// Handshake and data bundle for the gcd_param engine.
// The master drives operands and start; the slave returns status and results.
interface gcd_param_if #(
   parameter int unsigned WIDTH = 8
) ();
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] iters;

   modport master (
      output start, a, b,
      input  ready, busy, done, result, iters
   );

   modport slave (
      input  start, a, b,
      output ready, busy, done, result, iters
   );
endinterface

// File: rtl/gcd_param.sv
// Multi-cycle GCD engine, subtractive Euclid (MODE 0) or binary Stein (MODE 1).
// One operation in flight; zero operands finish on the accepting edge.
module gcd_param #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned MODE  = 0
) (
   input logic       clk,
   input logic       reset,
   gcd_param_if.slave bus
);
   localparam int unsigned KW = $clog2(WIDTH) + 1;

   typedef enum logic [0:0] {StIdle, StCalc} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] x_q;
   logic [WIDTH-1:0] y_q;
   logic [KW-1:0]    k_q;
   logic [WIDTH-1:0] step_q;
   logic [WIDTH-1:0] result_q;
   logic [WIDTH-1:0] iters_q;
   logic             done_q;

   assign bus.ready  = (state_q == StIdle);
   assign bus.busy   = (state_q == StCalc);
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.iters  = iters_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         x_q      <= '0;
         y_q      <= '0;
         k_q      <= '0;
         step_q   <= '0;
         result_q <= '0;
         iters_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  if (bus.a == '0 || bus.b == '0) begin
                     result_q <= bus.a | bus.b;
                     iters_q  <= '0;
                     done_q   <= 1'b1;
                  end else begin
                     x_q     <= bus.a;
                     y_q     <= bus.b;
                     k_q     <= '0;
                     step_q  <= '0;
                     state_q <= StCalc;
                  end
               end
            end
            StCalc: begin
               if (x_q == y_q) begin
                  result_q <= (MODE == 1) ? (x_q << k_q) : x_q;
                  iters_q  <= step_q;
                  done_q   <= 1'b1;
                  state_q  <= StIdle;
               end else begin
                  if (step_q != '1) begin
                     step_q <= step_q + WIDTH'(1);
                  end
                  if (MODE == 0) begin
                     if (x_q > y_q) begin
                        x_q <= x_q - y_q;
                     end else begin
                        y_q <= y_q - x_q;
                     end
                  end else begin
                     // Stein: factor out common twos into k, then strip lone twos.
                     if (!x_q[0] && !y_q[0]) begin
                        x_q <= x_q >> 1;
                        y_q <= y_q >> 1;
                        k_q <= k_q + KW'(1);
                     end else if (!x_q[0]) begin
                        x_q <= x_q >> 1;
                     end else if (!y_q[0]) begin
                        y_q <= y_q >> 1;
                     end else if (x_q > y_q) begin
                        x_q <= (x_q - y_q) >> 1;
                     end else begin
                        y_q <= (y_q - x_q) >> 1;
                     end
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end
endmodule

// File: tb/tb_gcd_param.sv
// Directed bench for gcd_param: four instances cover both modes at widths 8 and 16.
// Expected values are hand-derived from the algorithm definitions.
module tb_gcd_param;
   logic clk;
   logic reset;
   int   n_vec;
   int   n_fail;
   int   cyc;
   int   pc0;
   int   pc_snap;

   gcd_param_if #(.WIDTH(8))  i0 ();
   gcd_param_if #(.WIDTH(8))  i1 ();
   gcd_param_if #(.WIDTH(16)) i2 ();
   gcd_param_if #(.WIDTH(16)) i3 ();

   gcd_param #(.WIDTH(8),  .MODE(0)) u0 (.clk(clk), .reset(reset), .bus(i0.slave));
   gcd_param #(.WIDTH(8),  .MODE(1)) u1 (.clk(clk), .reset(reset), .bus(i1.slave));
   gcd_param #(.WIDTH(16), .MODE(0)) u2 (.clk(clk), .reset(reset), .bus(i2.slave));
   gcd_param #(.WIDTH(16), .MODE(1)) u3 (.clk(clk), .reset(reset), .bus(i3.slave));

   logic [3:0] done_v;
   assign done_v = {i3.done, i2.done, i1.done, i0.done};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial pc0 = 0;
   always @(posedge clk) if (i0.done === 1'b1) pc0 <= pc0 + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Wait on negedges until the selected done rises, bounded by max_cyc.
   task automatic wait_done(input int sel, input int max_cyc, output int n);
      n = 0;
      while (done_v[sel] !== 1'b1 && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("done_seen_%0d", sel), 32'(done_v[sel]), 32'd1);
   endtask

   initial begin
      n_vec = 0;
      n_fail = 0;
      reset = 1'b1;
      {i0.start, i1.start, i2.start, i3.start} = '0;
      i0.a = '0; i0.b = '0; i1.a = '0; i1.b = '0;
      i2.a = '0; i2.b = '0; i3.a = '0; i3.b = '0;
      @(negedge clk);
      check("rst_ready",  32'(i0.ready),  32'd1);
      check("rst_busy",   32'(i0.busy),   32'd0);
      check("rst_done",   32'(i0.done),   32'd0);
      check("rst_result", 32'(i3.result), 32'd0);
      check("rst_iters",  32'(i3.iters),  32'd0);
      @(negedge clk);
      reset = 1'b0;

      // MODE0 W8: 5,4 -> 4 steps, done after 6th edge from accept
      i0.a = 8'd5; i0.b = 8'd4; i0.start = 1'b1;
      @(negedge clk);
      i0.start = 1'b0;
      check("m0_busy", 32'(i0.busy), 32'd1);
      check("m0_ready", 32'(i0.ready), 32'd0);
      wait_done(0, 20, cyc);
      check("m0_latency", 32'(cyc), 32'd5);
      check("m0_result", 32'(i0.result), 32'd1);
      check("m0_iters", 32'(i0.iters), 32'd4);
      check("m0_ready_done", 32'(i0.ready), 32'd1);
      // back-to-back 2,2 in the done cycle
      i0.a = 8'd2; i0.b = 8'd2; i0.start = 1'b1;
      @(negedge clk);
      i0.start = 1'b0;
      check("b2b_done_low", 32'(i0.done), 32'd0);
      check("b2b_busy", 32'(i0.busy), 32'd1);
      wait_done(0, 10, cyc);
      check("b2b_latency", 32'(cyc), 32'd1);
      check("b2b_result", 32'(i0.result), 32'd2);
      check("b2b_iters", 32'(i0.iters), 32'd0);
      @(negedge clk);
      @(negedge clk);
      check("hold_done", 32'(i0.done), 32'd0);
      check("hold_result", 32'(i0.result), 32'd2);

      // zero operands, issued back to back with start held
      i0.a = 8'd0; i0.b = 8'd37; i0.start = 1'b1;
      @(negedge clk);
      check("z37_done", 32'(i0.done), 32'd1);
      check("z37_result", 32'(i0.result), 32'd37);
      check("z37_iters", 32'(i0.iters), 32'd0);
      check("z37_ready", 32'(i0.ready), 32'd1);
      i0.a = 8'd0; i0.b = 8'd0;
      @(negedge clk);
      i0.start = 1'b0;
      check("z00_done", 32'(i0.done), 32'd1);
      check("z00_result", 32'(i0.result), 32'd0);
      check("z00_ready", 32'(i0.ready), 32'd1);

      // prime result with a nonzero value so the reset clear is observable
      i0.a = 8'd6; i0.b = 8'd0; i0.start = 1'b1;
      @(negedge clk);
      i0.start = 1'b0;
      check("z6_result", 32'(i0.result), 32'd6);

      // reset mid-operation
      i0.a = 8'd255; i0.b = 8'd1; i0.start = 1'b1;
      @(negedge clk);
      i0.start = 1'b0;
      repeat (9) @(negedge clk);
      check("pre_rst_busy", 32'(i0.busy), 32'd1);
      pc_snap = pc0;
      reset = 1'b1;
      #1;
      check("mid_rst_ready", 32'(i0.ready), 32'd1);
      check("mid_rst_busy", 32'(i0.busy), 32'd0);
      check("mid_rst_result", 32'(i0.result), 32'd0);
      check("mid_rst_done", 32'(i0.done), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_rst_no_pulse", 32'(pc0 - pc_snap), 32'd0);
      i0.a = 8'd21; i0.b = 8'd24; i0.start = 1'b1;
      @(negedge clk);
      i0.start = 1'b0;
      wait_done(0, 50, cyc);
      check("r21_24_result", 32'(i0.result), 32'd3);

      // start ignored while busy: 100,72 with a stray 9,6 request
      @(negedge clk);
      pc_snap = pc0;
      i0.a = 8'd100; i0.b = 8'd72; i0.start = 1'b1;
      @(negedge clk);
      i0.start = 1'b0;
      @(negedge clk);
      i0.a = 8'd9; i0.b = 8'd6; i0.start = 1'b1;
      @(negedge clk);
      i0.start = 1'b0;
      wait_done(0, 100, cyc);
      check("ign_result", 32'(i0.result), 32'd4);
      repeat (4) @(negedge clk);
      check("ign_one_pulse", 32'(pc0 - pc_snap), 32'd1);

      // MODE1 W8: 20,24 -> 5 steps, k=2
      i1.a = 8'd20; i1.b = 8'd24; i1.start = 1'b1;
      @(negedge clk);
      i1.start = 1'b0;
      wait_done(1, 30, cyc);
      check("s20_latency", 32'(cyc), 32'd6);
      check("s20_result", 32'(i1.result), 32'd4);
      check("s20_iters", 32'(i1.iters), 32'd5);
      @(negedge clk);
      i1.a = 8'd200; i1.b = 8'd68; i1.start = 1'b1;
      @(negedge clk);
      i1.start = 1'b0;
      wait_done(1, 50, cyc);
      check("s200_result", 32'(i1.result), 32'd4);
      check("s200_iters", 32'(i1.iters), 32'd10);

      // WIDTH16 both modes: 65535,255
      i2.a = 16'd65535; i2.b = 16'd255; i2.start = 1'b1;
      i3.a = 16'd65535; i3.b = 16'd255; i3.start = 1'b1;
      @(negedge clk);
      i2.start = 1'b0;
      i3.start = 1'b0;
      wait_done(3, 100, cyc);
      check("w16s_result", 32'(i3.result), 32'd255);
      check("w16s_iters", 32'(i3.iters), 32'd8);
      wait_done(2, 400, cyc);
      check("w16e_result", 32'(i2.result), 32'd255);
      check("w16e_iters", 32'(i2.iters), 32'd256);
      @(negedge clk);
      i3.a = 16'd1024; i3.b = 16'd4096; i3.start = 1'b1;
      @(negedge clk);
      i3.start = 1'b0;
      wait_done(3, 100, cyc);
      check("w16p_result", 32'(i3.result), 32'd1024);
      check("w16p_iters", 32'(i3.iters), 32'd12);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
